// File: rtl/pc_sequencer_fsm.sv
// pc_sequencer_fsm: Moore controller that steps the program counter, latches the
// instruction word into the IR and sequences data RAM, register file and ALU.
//
// Ports:
//   clk         system clock, rising edge
//   clear       synchronous active-high reset (state -> Init, IR -> 0)
//   instr_in    instruction-memory read data for the current PC
//   pc_up       PC increment strobe (Fetch)
//   pc_clr      PC clear strobe (Init)
//   ir_out      instruction register contents
//   d_addr      data-RAM address
//   d_wr        data-RAM write enable
//   rf_s        register-file write-data select (1 = RAM, 0 = ALU)
//   rf_w_addr   register-file write address
//   rf_w_en     register-file write enable
//   rf_ra_addr  register-file read port A address
//   rf_rb_addr  register-file read port B address
//   alu_sel     ALU operation (000 zero, 001 add, 010 sub)
//   state_out   current state encoding
module pc_sequencer_fsm #(
  parameter int unsigned IW  = 16,
  parameter int unsigned DAW = 8,
  parameter int unsigned RAW = 4
) (
  input  logic           clk,
  input  logic           clear,
  input  logic [IW-1:0]  instr_in,
  output logic           pc_up,
  output logic           pc_clr,
  output logic [IW-1:0]  ir_out,
  output logic [DAW-1:0] d_addr,
  output logic           d_wr,
  output logic           rf_s,
  output logic [RAW-1:0] rf_w_addr,
  output logic           rf_w_en,
  output logic [RAW-1:0] rf_ra_addr,
  output logic [RAW-1:0] rf_rb_addr,
  output logic [2:0]     alu_sel,
  output logic [3:0]     state_out
);

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StNoOp   = 4'd3,
    StLoadA  = 4'd4,
    StLoadB  = 4'd5,
    StStore  = 4'd6,
    StAdd    = 4'd7,
    StSub    = 4'd8,
    StHalt   = 4'd9
  } state_e;

  localparam logic [3:0] OpNoOp  = 4'b0000;
  localparam logic [3:0] OpStore = 4'b0001;
  localparam logic [3:0] OpLoad  = 4'b0010;
  localparam logic [3:0] OpAdd   = 4'b0011;
  localparam logic [3:0] OpSub   = 4'b0100;
  localparam logic [3:0] OpHalt  = 4'b0101;

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [3:0]    opcode;

  assign opcode = ir_q[15:12];

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StInit;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state and IR load
  always_comb begin
    state_d = StInit;
    ir_d    = ir_q;
    case (state_q)
      StInit:  state_d = StFetch;
      StFetch: begin
        state_d = StDecode;
        ir_d    = instr_in;
      end
      StDecode: begin
        case (opcode)
          OpNoOp:  state_d = StNoOp;
          OpStore: state_d = StStore;
          OpLoad:  state_d = StLoadA;
          OpAdd:   state_d = StAdd;
          OpSub:   state_d = StSub;
          OpHalt:  state_d = StHalt;
          default: state_d = StNoOp;
        endcase
      end
      StLoadA: state_d = StLoadB;
      StLoadB, StStore, StAdd, StSub, StNoOp: state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StInit;  // illegal codes recover through Init
    endcase
  end

  // Outputs: decoded from state and IR only
  always_comb begin
    pc_up      = 1'b0;
    pc_clr     = 1'b0;
    d_addr     = '0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = '0;
    rf_w_en    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    alu_sel    = 3'b000;

    // Address fields stay on the ports outside Init so reads settle before strobes.
    if (state_q != StInit) begin
      case (opcode)
        OpLoad: begin
          d_addr    = ir_q[11:4];
          rf_w_addr = ir_q[3:0];
        end
        OpStore: begin
          rf_ra_addr = ir_q[11:8];
          d_addr     = ir_q[7:0];
        end
        OpAdd, OpSub: begin
          rf_ra_addr = ir_q[11:8];
          rf_rb_addr = ir_q[7:4];
          rf_w_addr  = ir_q[3:0];
        end
        default: ;
      endcase
    end

    case (state_q)
      StInit:  pc_clr = 1'b1;
      StFetch: pc_up  = 1'b1;
      StLoadA: rf_s   = 1'b1;  // RAM read latency cycle, no write yet
      StLoadB: begin
        rf_s    = 1'b1;
        rf_w_en = 1'b1;
      end
      StStore: d_wr = 1'b1;
      StAdd: begin
        alu_sel = 3'b001;
        rf_w_en = 1'b1;
      end
      StSub: begin
        alu_sel = 3'b010;
        rf_w_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign ir_out    = ir_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_pc_sequencer_fsm.sv
module tb_pc_sequencer_fsm;

  localparam logic [3:0] StInit   = 4'd0;
  localparam logic [3:0] StFetch  = 4'd1;
  localparam logic [3:0] StDecode = 4'd2;
  localparam logic [3:0] StNoOp   = 4'd3;
  localparam logic [3:0] StLoadA  = 4'd4;
  localparam logic [3:0] StLoadB  = 4'd5;
  localparam logic [3:0] StStore  = 4'd6;
  localparam logic [3:0] StAdd    = 4'd7;
  localparam logic [3:0] StSub    = 4'd8;
  localparam logic [3:0] StHalt   = 4'd9;

  typedef struct packed {
    logic [3:0]  st;
    logic        up;
    logic        clr;
    logic [15:0] ir;
    logic [7:0]  da;
    logic        dw;
    logic        rs;
    logic [3:0]  wa;
    logic        we;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
  } outs_t;

  logic        clk = 1'b0;
  logic        clear;
  logic [15:0] instr_in;
  logic        pc_up, pc_clr, d_wr, rf_s, rf_w_en;
  logic [15:0] ir_out;
  logic [7:0]  d_addr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state_out;
  logic [2:0]  alu_sel;

  int n_tests = 0;
  int n_fail  = 0;
  int up_cnt  = 0;
  int excl_viol = 0;
  logic [6:0] pc_model = '0;

  outs_t exp_q[$];
  string tag_q[$];

  pc_sequencer_fsm dut (
    .clk        (clk),
    .clear      (clear),
    .instr_in   (instr_in),
    .pc_up      (pc_up),
    .pc_clr     (pc_clr),
    .ir_out     (ir_out),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_en    (rf_w_en),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .alu_sel    (alu_sel),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  // Reference outputs for a given state and IR word
  function automatic outs_t model(input logic [3:0] st, input logic [15:0] ir);
    outs_t o;
    o    = '0;
    o.st = st;
    o.ir = ir;
    if (st != StInit) begin
      case (ir[15:12])
        4'h2: begin o.da = ir[11:4]; o.wa = ir[3:0]; end
        4'h1: begin o.ra = ir[11:8]; o.da = ir[7:0]; end
        4'h3, 4'h4: begin o.ra = ir[11:8]; o.rb = ir[7:4]; o.wa = ir[3:0]; end
        default: ;
      endcase
    end
    case (st)
      StInit:  o.clr = 1'b1;
      StFetch: o.up  = 1'b1;
      StLoadA: o.rs  = 1'b1;
      StLoadB: begin o.rs = 1'b1; o.we = 1'b1; end
      StStore: o.dw  = 1'b1;
      StAdd:   begin o.alu = 3'b001; o.we = 1'b1; end
      StSub:   begin o.alu = 3'b010; o.we = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t observe();
    return {state_out, pc_up, pc_clr, ir_out, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
            rf_ra_addr, rf_rb_addr, alu_sel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for the next edge, queue the expected post-edge outputs, then compare.
  task automatic cyc(input logic clr, input logic [15:0] instr, input logic [3:0] est,
                     input logic [15:0] eir, input string tag);
    outs_t e, a;
    string t;
    clear    = clr;
    instr_in = instr;
    exp_q.push_back(model(est, eir));
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    a = observe();
    n_tests++;
    assert (a === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, a, e);
    end
    if (pc_up === 1'b1) begin
      up_cnt++;
      pc_model = pc_model + 7'd1;
    end
    if (pc_clr === 1'b1) pc_model = '0;
    if ((pc_up & pc_clr) === 1'b1 || (d_wr & rf_w_en) === 1'b1) excl_viol++;
  endtask

  // Runs one instruction starting from a checked Fetch state; ends in Fetch (or Halt).
  task automatic run_instr(input logic [15:0] w, input string nm);
    cyc(1'b0, w, StDecode, w, {nm, "_dec"});
    case (w[15:12])
      4'h2: begin
        cyc(1'b0, ~w, StLoadA, w, {nm, "_lda"});
        cyc(1'b0, ~w, StLoadB, w, {nm, "_ldb"});
      end
      4'h1: cyc(1'b0, ~w, StStore, w, {nm, "_st"});
      4'h3: cyc(1'b0, ~w, StAdd, w, {nm, "_add"});
      4'h4: cyc(1'b0, ~w, StSub, w, {nm, "_sub"});
      4'h5: ;
      default: cyc(1'b0, ~w, StNoOp, w, {nm, "_nop"});
    endcase
    if (w[15:12] == 4'h5) cyc(1'b0, ~w, StHalt, w, {nm, "_halt"});
    else cyc(1'b0, ~w, StFetch, w, {nm, "_fetch"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    logic [6:0] pc_snap;

    // Reset from unknown state
    cyc(1'b1, 16'h0000, StInit, 16'h0000, "rst_a");
    cyc(1'b1, 16'h0000, StInit, 16'h0000, "rst_b");
    chk("rst_pc_clr", {31'd0, pc_clr}, 32'd1);
    chk("rst_state", {28'd0, state_out}, 32'd0);
    snap = up_cnt;
    cyc(1'b0, 16'hFFFF, StFetch, 16'h0000, "rel_fetch");

    // LOAD with explicit field checks
    cyc(1'b0, 16'h2A53, StDecode, 16'h2A53, "load_dec");
    chk("load_d_addr", {24'd0, d_addr}, 32'hA5);
    chk("load_w_addr", {28'd0, rf_w_addr}, 32'd3);
    cyc(1'b0, 16'h0000, StLoadA, 16'h2A53, "load_a");
    chk("loada_rf_we", {31'd0, rf_w_en}, 32'd0);
    cyc(1'b0, 16'h0000, StLoadB, 16'h2A53, "load_b");
    chk("load_up_once", snap, up_cnt - 1);
    cyc(1'b0, 16'h0000, StFetch, 16'h2A53, "load_fetch");

    // ADD then SUB
    cyc(1'b0, 16'h3124, StDecode, 16'h3124, "add_dec");
    chk("add_fields", {20'd0, rf_ra_addr, rf_rb_addr, rf_w_addr}, 32'h124);
    cyc(1'b0, 16'hAAAA, StAdd, 16'h3124, "add_exe");
    chk("add_alu", {29'd0, alu_sel}, 32'd1);
    cyc(1'b0, 16'hAAAA, StFetch, 16'h3124, "add_fetch");
    run_instr(16'h4124, "sub");

    // STORE
    cyc(1'b0, 16'h1B7F, StDecode, 16'h1B7F, "st_dec");
    cyc(1'b0, 16'h5555, StStore, 16'h1B7F, "st_exe");
    chk("st_fields", {20'd0, rf_ra_addr, d_addr}, 32'hB7F);
    cyc(1'b0, 16'h5555, StFetch, 16'h1B7F, "st_fetch");

    // Illegal opcode behaves as NoOp
    run_instr(16'hF000, "ill");

    // Clear during LoadA
    cyc(1'b0, 16'h2A53, StDecode, 16'h2A53, "mid_dec");
    cyc(1'b0, 16'h0000, StLoadA, 16'h2A53, "mid_lda");
    cyc(1'b1, 16'h0000, StInit, 16'h0000, "mid_rst");
    chk("mid_ir", {16'd0, ir_out}, 32'd0);
    cyc(1'b0, 16'h0000, StFetch, 16'h0000, "mid_fetch");

    // 128 instructions -> 128 pc_up pulses, PC wraps back to its start value
    snap    = up_cnt;
    pc_snap = pc_model;
    run_instr(16'h2A53, "w_load");
    run_instr(16'h1B7F, "w_store");
    for (int i = 0; i < 126; i++) run_instr({4'h0, 12'(i * 37)}, "w_nop");
    chk("wrap_up_cnt", up_cnt - snap, 32'd128);
    chk("wrap_pc", {25'd0, pc_model}, {25'd0, pc_snap});

    // HALT held for 20 cycles, then cleared
    snap = up_cnt;
    run_instr(16'h5000, "halt");
    for (int i = 0; i < 19; i++) cyc(1'b0, 16'h2A53, StHalt, 16'h5000, "halt_hold");
    chk("halt_no_up", up_cnt, snap);
    cyc(1'b1, 16'h0000, StInit, 16'h0000, "halt_clr");
    cyc(1'b0, 16'h0000, StFetch, 16'h0000, "halt_refetch");

    chk("mutual_excl", excl_viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
